// File: rtl/reg_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wr_arb
//  Purpose  : Register-file write-port arbiter. Two writeback sources (req0 =
//             execute result, req1 = memory-load return) share one write
//             port. Valid/ready handshakes, a starvation guard for req1,
//             oldest-first ordering on same-register collisions, and a
//             registered write port with one cycle of latency.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_wr_arb #(
    parameter int IDX_W      = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [IDX_W-1:0]  req0_index,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req0_scope,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [IDX_W-1:0]  req1_index,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [1:0]        req1_scope,
    output logic              req1_ready,
    output logic              we,
    output logic [IDX_W-1:0]  reg_w_index,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        wr_scope,
    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic              w_grant0;
    logic              w_grant1;
    logic              w_both;
    logic              w_same_idx;
    logic              w_starved;

    logic [3:0]        r_starve_cnt;
    logic              r_we;
    logic [IDX_W-1:0]  r_index;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_scope;

    // Grant selection: hold blocks everything; a lone requester always wins;
    // on contention the load wins when it targets the same register (it is
    // older, so the execute result must land last) or when it has starved.
    always_comb begin
        w_both     = req0_valid && req1_valid;
        w_same_idx = (req0_index == req1_index);
        w_starved  = (r_starve_cnt == C_STARVE_MAX);
        w_grant0   = 1'b0;
        w_grant1   = 1'b0;
        if (!hold) begin
            if (w_both) begin
                if (w_same_idx || w_starved) begin
                    w_grant1 = 1'b1;
                end else begin
                    w_grant0 = 1'b1;
                end
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    // Ready is forced low while the block is held in reset so no requester
    // believes it was accepted by a flop that cannot capture it.
    assign req0_ready = w_grant0 && rst_n;
    assign req1_ready = w_grant1 && rst_n;

    // Consecutive-loss counter for req1; saturates so the forced grant fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant1 || !req1_valid || hold) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant0) begin
            if (r_starve_cnt < C_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    // Registered write port: reloads on every grant, otherwise only we drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_index <= '0;
            r_data  <= '0;
            r_scope <= 2'b00;
        end else begin
            r_we <= w_grant0 || w_grant1;
            if (w_grant1) begin
                r_index <= req1_index;
                r_data  <= req1_data;
                r_scope <= req1_scope;
            end else if (w_grant0) begin
                r_index <= req0_index;
                r_data  <= req0_data;
                r_scope <= req0_scope;
            end
        end
    end

    assign we          = r_we;
    assign reg_w_index = r_index;
    assign wr_data     = r_data;
    assign wr_scope    = r_scope;
    assign starve_cnt  = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_wr_arb
//  Purpose  : Self-checking bench for reg_wr_arb. A behavioural model of the
//             arbitration rules predicts ready, write-port and starve values;
//             directed scenarios add fixed expected values on top.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wr_arb;

    localparam int IDX_W      = 5;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold;
    logic              req0_valid;
    logic [IDX_W-1:0]  req0_index;
    logic [DATA_W-1:0] req0_data;
    logic [1:0]        req0_scope;
    logic              req0_ready;
    logic              req1_valid;
    logic [IDX_W-1:0]  req1_index;
    logic [DATA_W-1:0] req1_data;
    logic [1:0]        req1_scope;
    logic              req1_ready;
    logic              we;
    logic [IDX_W-1:0]  reg_w_index;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        wr_scope;
    logic [3:0]        starve_cnt;

    reg_wr_arb #(
        .IDX_W      (IDX_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .req0_valid  (req0_valid),
        .req0_index  (req0_index),
        .req0_data   (req0_data),
        .req0_scope  (req0_scope),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_index  (req1_index),
        .req1_data   (req1_data),
        .req1_scope  (req1_scope),
        .req1_ready  (req1_ready),
        .we          (we),
        .reg_w_index (reg_w_index),
        .wr_data     (wr_data),
        .wr_scope    (wr_scope),
        .starve_cnt  (starve_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the file's write port should show, and
    // how many times in a row the load source has lost.
    bit                m_we;
    logic [IDX_W-1:0]  m_idx;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_scope;
    int                m_starve;

    bit                acc0, acc1;
    logic [1:0]        exp_rdy, obs_rdy;
    logic [43:0]       exp_out, obs_out;

    function automatic void model_grant(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n !== 1'b1 || hold) return;
        if (req0_valid && !req1_valid)      g0 = 1'b1;
        else if (req1_valid && !req0_valid) g1 = 1'b1;
        else if (req0_valid && req1_valid) begin
            if (req0_index == req1_index)   g1 = 1'b1;
            else if (m_starve == STARVE_MAX) g1 = 1'b1;
            else                             g0 = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        m_we = 1'b0; m_idx = '0; m_data = '0; m_scope = 2'b00; m_starve = 0;
    endfunction

    function automatic void model_edge(input bit g0, input bit g1);
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        if (g0) begin
            m_idx = req0_index; m_data = req0_data; m_scope = req0_scope;
        end
        if (g1) begin
            m_idx = req1_index; m_data = req1_data; m_scope = req1_scope;
        end
        m_we = g0 | g1;
        if (g1 || !req1_valid || hold) m_starve = 0;
        else if (g0)                   m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    endfunction

    // One clock of operation; inputs are already applied at the falling edge.
    // Captures observed/predicted ready before the edge and outputs after it.
    task automatic step();
        bit g0, g1;
        #1;
        model_grant(g0, g1);
        exp_rdy = {g0, g1};
        obs_rdy = {req0_ready, req1_ready};
        @(posedge clk);
        acc0 = g0;
        acc1 = g1;
        model_edge(g0, g1);
        @(negedge clk);
        exp_out = {m_we, m_idx, m_data, m_scope, 4'(m_starve)};
        obs_out = {we, reg_w_index, wr_data, wr_scope, starve_cnt};
    endtask

    task automatic test_reset();
        hold = 1'b0;
        req0_valid = 1'b1; req0_index = 5'd4; req0_data = 32'hDEAD; req0_scope = 2'd1;
        req1_valid = 1'b1; req1_index = 5'd8; req1_data = 32'hBEEF; req1_scope = 2'd2;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (obs_rdy !== 2'b00) begin
                failures++; $display("FAIL reset_ready[%0d]: got %b want 00", i, obs_rdy);
            end
            checks++;
            if (obs_out !== 44'd0) begin
                failures++; $display("FAIL reset_outputs[%0d]: got %h want 0", i, obs_out);
            end
            checks++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            if (obs_rdy !== 2'b00 || obs_out !== 44'd0) begin
                failures++; $display("FAIL idle[%0d]: got rdy=%b out=%h want rdy=00 out=0", i, obs_rdy, obs_out);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            req0_valid = 1'b1; req0_index = 5'(i); req0_data = 32'h1230311 + 32'(i); req0_scope = 2'd1;
            step();
            if (obs_rdy !== 2'b10) begin
                failures++; $display("FAIL b2b_ready[%0d]: got %b want 10", i, obs_rdy);
            end
            checks++;
            if (we !== 1'b1 || reg_w_index !== 5'(i) || wr_data !== 32'h1230311 + 32'(i) || wr_scope !== 2'd1) begin
                failures++;
                $display("FAIL b2b_write[%0d]: got we=%b idx=%0d data=%h scope=%0d want we=1 idx=%0d data=%h scope=1",
                         i, we, reg_w_index, wr_data, wr_scope, i, 32'h1230311 + 32'(i));
            end
            checks++;
        end
        req0_valid = 1'b0;
        step();
        if (we !== 1'b0 || obs_out !== exp_out) begin
            failures++; $display("FAIL b2b_drain: got we=%b out=%h want we=0 out=%h", we, obs_out, exp_out);
        end
        checks++;
    endtask

    task automatic test_starvation();
        logic [1:0] want_rdy;
        logic [3:0] want_cnt;
        req1_valid = 1'b1; req1_index = 5'd9; req1_data = 32'h0000_9999; req1_scope = 2'd3;
        req0_valid = 1'b1; req0_index = 5'd2; req0_scope = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (c == 0 || acc0) req0_data = $urandom;
            step();
            want_rdy = (c < 3) ? 2'b10 : 2'b01;
            want_cnt = (c < 3) ? 4'(c + 1) : 4'd0;
            if (obs_rdy !== want_rdy) begin
                failures++; $display("FAIL starve_grant[%0d]: got %b want %b", c, obs_rdy, want_rdy);
            end
            checks++;
            if (starve_cnt !== want_cnt) begin
                failures++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", c, starve_cnt, want_cnt);
            end
            checks++;
            if (obs_out !== exp_out) begin
                failures++; $display("FAIL starve_model[%0d]: got %h want %h", c, obs_out, exp_out);
            end
            checks++;
        end
        if (wr_data !== 32'h0000_9999 || reg_w_index !== 5'd9 || wr_scope !== 2'd3) begin
            failures++; $display("FAIL starve_forced_write: got idx=%0d data=%h want idx=9 data=00009999", reg_w_index, wr_data);
        end
        checks++;
        req1_valid = 1'b0;
        step();
        if (obs_rdy !== 2'b10) begin
            failures++; $display("FAIL starve_leftover: got %b want 10", obs_rdy);
        end
        checks++;
        req0_valid = 1'b0;
    endtask

    task automatic test_collision();
        req0_valid = 1'b1; req0_index = 5'd7; req0_data = 32'h0000_AAAA; req0_scope = 2'd1;
        req1_valid = 1'b1; req1_index = 5'd7; req1_data = 32'h0000_5555; req1_scope = 2'd2;
        step();
        if (obs_rdy !== 2'b01 || we !== 1'b1 || wr_data !== 32'h0000_5555) begin
            failures++; $display("FAIL collision_first: got rdy=%b we=%b data=%h want rdy=01 we=1 data=00005555", obs_rdy, we, wr_data);
        end
        checks++;
        req1_valid = 1'b0;
        step();
        if (obs_rdy !== 2'b10 || we !== 1'b1 || wr_data !== 32'h0000_AAAA || reg_w_index !== 5'd7) begin
            failures++; $display("FAIL collision_second: got rdy=%b we=%b data=%h want rdy=10 we=1 data=0000aaaa", obs_rdy, we, wr_data);
        end
        checks++;
        req0_valid = 1'b0;
    endtask

    task automatic test_hold();
        for (int k = 0; k < 6; k++) begin
            if (k == 0 || acc0) begin
                req0_valid = 1'b1; req0_index = 5'($urandom_range(0, 31));
                req0_data = $urandom; req0_scope = 2'($urandom_range(0, 3));
            end
            hold = (k == 2 || k == 3);
            step();
            if (req0_ready !== 1'bx && obs_rdy[1] !== ~hold) begin
                failures++; $display("FAIL hold_ready[%0d]: got %b want %b", k, obs_rdy[1], ~hold);
            end
            checks++;
            if (we !== ~hold || obs_out !== exp_out) begin
                failures++; $display("FAIL hold_write[%0d]: got we=%b out=%h want we=%b out=%h", k, we, obs_out, ~hold, exp_out);
            end
            checks++;
        end
        hold = 1'b0;
        req0_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_index = 5'd3; req0_data = 32'h3333_0000; req0_scope = 2'd1;
        step();
        if (we !== 1'b1) begin
            failures++; $display("FAIL midrst_setup: got we=%b want 1", we);
        end
        checks++;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_index = 5'd6; req1_data = 32'h6666_1234; req1_scope = 2'd2;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        if (we !== 1'b0 || req1_ready !== 1'b0 || reg_w_index !== 5'd0 || wr_data !== 32'd0) begin
            failures++; $display("FAIL midrst_clear: got we=%b rdy1=%b idx=%0d data=%h want 0 0 0 0", we, req1_ready, reg_w_index, wr_data);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        if (obs_rdy !== 2'b01) begin
            failures++; $display("FAIL midrst_regrant: got %b want 01", obs_rdy);
        end
        checks++;
        if (we !== 1'b1 || reg_w_index !== 5'd6 || wr_data !== 32'h6666_1234 || wr_scope !== 2'd2) begin
            failures++; $display("FAIL midrst_write: got we=%b idx=%0d data=%h want we=1 idx=6 data=66661234", we, reg_w_index, wr_data);
        end
        checks++;
        req1_valid = 1'b0;
    endtask

    task automatic test_random();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_index = 5'($urandom_range(0, 3));
                req0_data  = $urandom;
                req0_scope = 2'($urandom_range(0, 3));
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 1) != 0);
                req1_index = 5'($urandom_range(0, 3));
                req1_data  = $urandom;
                req1_scope = 2'($urandom_range(0, 3));
            end
            hold = ($urandom_range(0, 7) == 0);
            step();
            if (obs_rdy !== exp_rdy) begin
                failures++; $display("FAIL rand_ready[%0d]: got %b want %b", n, obs_rdy, exp_rdy);
            end
            checks++;
            if (obs_out !== exp_out) begin
                failures++; $display("FAIL rand_out[%0d]: got %h want %h", n, obs_out, exp_out);
            end
            checks++;
        end
        hold = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        acc0 = 1'b0;
        acc1 = 1'b0;
        test_reset();
        test_back_to_back();
        test_starvation();
        test_collision();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
